// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain with per-stage flush and occupancy count.
// Define PIPE_SKID_EN for 2-entry skid stages whose ready is registered.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  input  logic [STAGES-1:0]             flush_mask,
  output logic [$clog2(2*STAGES+1)-1:0] occupancy
);
  localparam int OCC_W = $clog2(2*STAGES+1);

  logic [STAGES-1:0] r_main_valid;
  logic [WIDTH-1:0]  r_main_data [STAGES];
  logic [STAGES-1:0] w_up_valid;
  logic [WIDTH-1:0]  w_up_data [STAGES];
  logic [STAGES-1:0] w_stage_ready;
  logic [STAGES-1:0] w_down_ready;
  logic [STAGES-1:0] w_push;
  logic [STAGES-1:0] w_pop;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_link
      if (gi == 0) begin : g_head
        assign w_up_valid[gi] = in_valid;
        assign w_up_data[gi]  = in_data;
      end else begin : g_body
        assign w_up_valid[gi] = r_main_valid[gi-1];
        assign w_up_data[gi]  = r_main_data[gi-1];
      end
      assign w_push[gi] = w_up_valid[gi] & w_stage_ready[gi];
      assign w_pop[gi]  = r_main_valid[gi] & w_down_ready[gi];
    end
  endgenerate

`ifdef PIPE_SKID_EN
  logic [STAGES-1:0] r_skid_valid;
  logic [WIDTH-1:0]  r_skid_data [STAGES];

  // A stage is ready while its skid slot is free, so ready never sees out_ready.
  always_comb begin
    w_stage_ready          = ~r_skid_valid;
    w_down_ready           = '0;
    w_down_ready[STAGES-1] = out_ready;
    for (int i = 0; i < STAGES-1; i++) begin
      w_down_ready[i] = ~r_skid_valid[i+1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst || flush_mask[i]) begin
        r_main_valid[i] <= 1'b0;
        r_skid_valid[i] <= 1'b0;
      end else if (r_skid_valid[i]) begin
        // Skid entry is older than anything upstream: it refills main first.
        if (w_pop[i]) begin
          r_main_data[i]  <= r_skid_data[i];
          r_skid_valid[i] <= 1'b0;
        end
      end else if (w_push[i] && r_main_valid[i] && !w_pop[i]) begin
        r_skid_data[i]  <= w_up_data[i];
        r_skid_valid[i] <= 1'b1;
      end else if (w_push[i]) begin
        r_main_data[i]  <= w_up_data[i];
        r_main_valid[i] <= 1'b1;
      end else if (w_pop[i]) begin
        r_main_valid[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(r_main_valid[i]) + OCC_W'(r_skid_valid[i]);
    end
  end
`else
  // Ready ripples back from out_ready through every occupied stage.
  always_comb begin
    logic w_rdy;
    w_rdy         = out_ready;
    w_stage_ready = '0;
    w_down_ready  = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      w_down_ready[i]  = w_rdy;
      w_stage_ready[i] = ~r_main_valid[i] | w_rdy;
      w_rdy            = w_stage_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst || flush_mask[i]) begin
        r_main_valid[i] <= 1'b0;
      end else if (w_push[i]) begin
        r_main_valid[i] <= 1'b1;
      end else if (w_pop[i]) begin
        r_main_valid[i] <= 1'b0;
      end
      if (w_push[i]) begin
        r_main_data[i] <= w_up_data[i];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + OCC_W'(r_main_valid[i]);
    end
  end
`endif

  assign in_ready  = w_stage_ready[0];
  assign out_valid = r_main_valid[STAGES-1];
  assign out_data  = r_main_data[STAGES-1];

endmodule
